// File: rtl/ntt_pkg.sv
`default_nettype none
// ==== ntt_pkg | shared constants and mode encodings for the NTT butterfly | rev 1.0 ====
package ntt_pkg;

  localparam int unsigned NTT_W       = 16;
  localparam int unsigned NTT_Q       = 12289;
  localparam int unsigned NTT_R_BITS  = 18;
  localparam int unsigned NTT_QINV    = 12287;
  localparam int unsigned NTT_TAG_W   = 10;
  localparam int unsigned NTT_R_MOD_Q = (32'd1 << NTT_R_BITS) % NTT_Q;

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/montgomery_reduce_pipe.sv
`default_nettype none
// ==== montgomery_reduce_pipe | two-register Montgomery reduction, final correction on output | rev 1.0 ====
module montgomery_reduce_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned W      = NTT_W,
  parameter int unsigned Q      = NTT_Q,
  parameter int unsigned R_BITS = NTT_R_BITS,
  parameter int unsigned QINV   = NTT_QINV
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2*W-1:0]   prod_in,
  output logic [W-1:0]     res_out
);

  // Sum width covers both the 2W-bit product and the (R_BITS+W)-bit m*Q term plus carry.
  localparam int unsigned SW = ((2 * W > R_BITS + W) ? 2 * W : R_BITS + W) + 1;
  localparam int unsigned RW = SW - R_BITS;
  localparam logic [R_BITS-1:0] QINV_R = R_BITS'(QINV);
  localparam logic [RW-1:0]     Q_R    = RW'(Q);

  logic [2*W-1:0]    p_q, p_d;
  logic [R_BITS-1:0] m_q, m_d;
  logic [RW-1:0]     r_q, r_d;
  logic [SW-1:0]     acc;

  assign acc = SW'(p_q) + SW'(m_q) * SW'(Q);

  always_comb begin
    p_d = p_q;
    m_d = m_q;
    r_d = r_q;
    if (en) begin
      p_d = prod_in;
      m_d = prod_in[R_BITS-1:0] * QINV_R;
      r_d = RW'(acc >> R_BITS);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q <= '0;
      m_q <= '0;
      r_q <= '0;
    end else begin
      p_q <= p_d;
      m_q <= m_d;
      r_q <= r_d;
    end
  end

  // r_q < 2Q for any product below Q*R, so one subtract fully reduces it.
  assign res_out = (r_q >= Q_R) ? W'(r_q - Q_R) : W'(r_q);

endmodule
`default_nettype wire

// File: rtl/ntt_butterfly_pipe.sv
`default_nettype none
// ==== ntt_butterfly_pipe | 5-stage CT/GS NTT butterfly with Montgomery twiddle multiply | rev 1.0 ====
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned W      = NTT_W,
  parameter int unsigned Q      = NTT_Q,
  parameter int unsigned R_BITS = NTT_R_BITS,
  parameter int unsigned QINV   = NTT_QINV,
  parameter int unsigned TAG_W  = NTT_TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     a_pair,
  input  logic [W-1:0]     omega,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     b_sum,
  output logic [W-1:0]     b_diff,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [W-1:0] QW = W'(Q);

  logic               en;
  logic [W-1:0]       a_q, a_d, ap_q, ap_d, om_q, om_d;
  logic [2*W-1:0]     prod_q, prod_d;
  logic [W-1:0]       lin_q [2:4];
  logic [W-1:0]       lin_d [2:4];
  mode_e              mode_q [1:4];
  mode_e              mode_d [1:4];
  logic [TAG_W-1:0]   tag_q [1:5];
  logic [TAG_W-1:0]   tag_d [1:5];
  logic [5:1]         vld_q, vld_d;
  logic [W-1:0]       b_sum_q, b_sum_d, b_diff_q, b_diff_d;

  logic [W:0]         gs_diff, sum_raw, ct_sum, ct_diff;
  logic [W-1:0]       sum_red, mul_x, t_red;

  // Whole pipe advances together; only a held output blocks it.
  assign en = !(vld_q[5] && !out_ready);

  assign gs_diff = {1'b0, a_q} + {1'b0, QW} - {1'b0, ap_q};
  assign sum_raw = {1'b0, a_q} + {1'b0, ap_q};
  assign sum_red = (sum_raw >= {1'b0, QW}) ? W'(sum_raw - {1'b0, QW}) : W'(sum_raw);
  assign mul_x   = (mode_q[1] == MODE_GS) ? W'(gs_diff) : ap_q;
  assign ct_sum  = {1'b0, lin_q[4]} + {1'b0, t_red};
  assign ct_diff = {1'b0, lin_q[4]} + {1'b0, QW} - {1'b0, t_red};

  always_comb begin
    a_d      = a_q;
    ap_d     = ap_q;
    om_d     = om_q;
    prod_d   = prod_q;
    lin_d    = lin_q;
    mode_d   = mode_q;
    tag_d    = tag_q;
    vld_d    = vld_q;
    b_sum_d  = b_sum_q;
    b_diff_d = b_diff_q;
    if (en) begin
      a_d       = a;
      ap_d      = a_pair;
      om_d      = omega;
      mode_d[1] = mode_e'(mode);
      tag_d[1]  = tag_in;
      prod_d    = {{W{1'b0}}, mul_x} * {{W{1'b0}}, om_q};
      // Linear operand: a for CT, the finished sum for GS, delayed to meet the reducer.
      lin_d[2]  = (mode_q[1] == MODE_GS) ? sum_red : a_q;
      for (int i = 3; i <= 4; i++) lin_d[i] = lin_q[i-1];
      for (int i = 2; i <= 4; i++) mode_d[i] = mode_q[i-1];
      for (int i = 2; i <= 5; i++) tag_d[i] = tag_q[i-1];
      vld_d = {vld_q[4:1], in_valid};
      if (mode_q[4] == MODE_GS) begin
        b_sum_d  = lin_q[4];
        b_diff_d = t_red;
      end else begin
        b_sum_d  = (ct_sum  >= {1'b0, QW}) ? W'(ct_sum  - {1'b0, QW}) : W'(ct_sum);
        b_diff_d = (ct_diff >= {1'b0, QW}) ? W'(ct_diff - {1'b0, QW}) : W'(ct_diff);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      ap_q     <= '0;
      om_q     <= '0;
      prod_q   <= '0;
      vld_q    <= '0;
      b_sum_q  <= '0;
      b_diff_q <= '0;
      for (int i = 2; i <= 4; i++) lin_q[i] <= '0;
      for (int i = 1; i <= 4; i++) mode_q[i] <= MODE_CT;
      for (int i = 1; i <= 5; i++) tag_q[i] <= '0;
    end else begin
      a_q      <= a_d;
      ap_q     <= ap_d;
      om_q     <= om_d;
      prod_q   <= prod_d;
      vld_q    <= vld_d;
      b_sum_q  <= b_sum_d;
      b_diff_q <= b_diff_d;
      lin_q    <= lin_d;
      mode_q   <= mode_d;
      tag_q    <= tag_d;
    end
  end

  montgomery_reduce_pipe #(
    .W      (W),
    .Q      (Q),
    .R_BITS (R_BITS),
    .QINV   (QINV)
  ) u_mred (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .prod_in (prod_q),
    .res_out (t_red)
  );

  assign in_ready  = en;
  assign out_valid = vld_q[5];
  assign b_sum     = b_sum_q;
  assign b_diff    = b_diff_q;
  assign tag_out   = tag_q[5];

endmodule
`default_nettype wire

// File: tb/tb_ntt_butterfly_pipe.sv
`default_nettype none
// ==== tb_ntt_butterfly_pipe | randomized self-checking bench against a modular-arithmetic model | rev 1.0 ====
module tb_ntt_butterfly_pipe;

  localparam int W        = 16;
  localparam int Q        = 12289;
  localparam int TAG_W    = 10;
  localparam int MONT_ONE = 4075;
  localparam longint unsigned QL = 64'd12289;
  localparam longint unsigned RL = 64'd262144;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mode = 1'b0;
  logic [W-1:0]     a = '0, a_pair = '0, omega = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     b_sum, b_diff;
  logic [TAG_W-1:0] tag_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  longint unsigned rinv;

  typedef struct {
    logic [W-1:0]     s;
    logic [W-1:0]     d;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;
  exp_t exp_q[$];

  ntt_butterfly_pipe #(
    .W(16), .Q(12289), .R_BITS(18), .QINV(12287), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .a_pair(a_pair), .omega(omega), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .b_sum(b_sum), .b_diff(b_diff), .tag_out(tag_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic longint unsigned modpow(longint unsigned b, longint unsigned e, longint unsigned m);
    longint unsigned r = 1;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // x * R^-1 mod Q in plain modular arithmetic
  function automatic longint unsigned mred(longint unsigned x);
    return ((x % QL) * rinv) % QL;
  endfunction

  function automatic void model(input logic m, input logic [W-1:0] av, apv, omv,
                                output logic [W-1:0] s, d);
    longint unsigned la, lp, lo, t;
    la = 64'(av); lp = 64'(apv); lo = 64'(omv);
    if (m == 1'b0) begin
      t = mred(lp * lo);
      s = W'((la + t) % QL);
      d = W'((la + QL - t) % QL);
    end else begin
      s = W'((la + lp) % QL);
      d = W'(mred(lo * (la + QL - lp)));
    end
  endfunction

  function automatic logic [W-1:0] rnd_op();
    int unsigned r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return W'(Q - 1);
    return W'($urandom_range(0, Q - 1));
  endfunction

  task automatic step(input logic iv, input logic m, input logic [W-1:0] av, apv, omv,
                      input logic [TAG_W-1:0] tg, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid = iv; mode = m; a = av; a_pair = apv; omega = omv; tag_in = tg; out_ready = ordy;
    #1;
    acc = iv & in_ready;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (b_sum !== '0) begin fails++; $display("FAIL reset_b_sum: got %0d want 0", b_sum); end
    tests++; if (b_diff !== '0) begin fails++; $display("FAIL reset_b_diff: got %0d want 0", b_diff); end
    tests++; if (tag_out !== '0) begin fails++; $display("FAIL reset_tag_out: got %0d want 0", tag_out); end
    @(posedge clk); #2 reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic         vm [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] va [4] = '{16'd5, 16'd5, 16'd0, 16'd12288};
    logic [W-1:0] vp [4] = '{16'd3, 16'd3, 16'd1, 16'd12288};
    logic [W-1:0] vs [4] = '{16'd8, 16'd8, 16'd1, 16'd12287};
    logic [W-1:0] vd [4] = '{16'd2, 16'd2, 16'd12288, 16'd0};
    exp_t e; logic acc; int sent = 0;
    for (int k = 0; k < 40; k++) begin
      if (sent < 4) step(1'b1, vm[sent], va[sent], vp[sent], W'(MONT_ONE), TAG_W'(sent + 100), 1'b1, acc);
      else          step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, acc);
      if (k == 0) begin
        tests++; if (acc !== 1'b1) begin fails++; $display("FAIL first_accept_after_reset: got %b want 1", acc); end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL directed_spurious: out_valid=1 want no output"); end
        else begin
          e = exp_q.pop_front();
          if (b_sum !== e.s || b_diff !== e.d || tag_out !== e.tag) begin
            fails++; $display("FAIL directed_data: got %0d/%0d tag %0d want %0d/%0d tag %0d", b_sum, b_diff, tag_out, e.s, e.d, e.tag);
          end
          tests++; if (cyc - e.cyc != 5) begin fails++; $display("FAIL directed_latency: got %0d want 5", cyc - e.cyc); end
        end
      end
      if (acc) begin exp_q.push_back('{vs[sent], vd[sent], TAG_W'(sent + 100), cyc}); sent++; end
      if (sent == 4 && exp_q.size() == 0) break;
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL directed_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic acc; int sent = 0;
    logic m; logic [W-1:0] av, apv, omv, s, d; logic [TAG_W-1:0] tg;
    for (int k = 0; k < 80; k++) begin
      m = 1'(k % 2 == 0 ? $urandom_range(0, 1) : (k % 4 == 1)); av = rnd_op(); apv = rnd_op(); omv = rnd_op();
      tg = TAG_W'($urandom); model(m, av, apv, omv, s, d);
      step(sent < 24, m, av, apv, omv, tg, 1'b1, acc);
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_spurious: out_valid=1 want no output"); end
        else begin
          e = exp_q.pop_front();
          if (b_sum !== e.s || b_diff !== e.d || tag_out !== e.tag) begin
            fails++; $display("FAIL b2b_data: got %0d/%0d tag %0d want %0d/%0d tag %0d", b_sum, b_diff, tag_out, e.s, e.d, e.tag);
          end
          tests++; if (cyc - e.cyc != 5) begin fails++; $display("FAIL b2b_latency: got %0d want 5", cyc - e.cyc); end
        end
      end
      if (acc) begin exp_q.push_back('{s, d, tg, cyc}); sent++; end
      if (sent == 24 && exp_q.size() == 0) break;
    end
    tests++; if (exp_q.size() != 0 || sent != 24) begin fails++; $display("FAIL b2b_drain: left %0d sent %0d want 0/24", exp_q.size(), sent); end
  endtask

  task automatic test_stall();
    exp_t e; logic acc; int sent = 0; logic ordy;
    logic m; logic [W-1:0] av, apv, omv, s, d; logic [TAG_W-1:0] tg;
    m = 1'($urandom_range(0, 1)); av = rnd_op(); apv = rnd_op(); omv = rnd_op(); tg = TAG_W'($urandom);
    for (int k = 0; k < 80; k++) begin
      model(m, av, apv, omv, s, d);
      ordy = !(k >= 7 && k <= 9);
      step(sent < 20, m, av, apv, omv, tg, ordy, acc);
      tests++; if (in_ready !== ordy) begin fails++; $display("FAIL stall_in_ready cycle %0d: got %b want %b", k, in_ready, ordy); end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL stall_spurious: out_valid=1 want no output"); end
        else begin
          e = exp_q.pop_front();
          if (b_sum !== e.s || b_diff !== e.d || tag_out !== e.tag) begin
            fails++; $display("FAIL stall_data: got %0d/%0d tag %0d want %0d/%0d tag %0d", b_sum, b_diff, tag_out, e.s, e.d, e.tag);
          end
        end
      end
      if (acc) begin
        exp_q.push_back('{s, d, tg, cyc}); sent++;
        m = 1'($urandom_range(0, 1)); av = rnd_op(); apv = rnd_op(); omv = rnd_op(); tg = TAG_W'($urandom);
      end
      if (sent == 20 && exp_q.size() == 0) break;
    end
    tests++; if (exp_q.size() != 0 || sent != 20) begin fails++; $display("FAIL stall_drain: left %0d sent %0d want 0/20", exp_q.size(), sent); end
  endtask

  task automatic test_random_flow();
    exp_t e; logic acc; int sent = 0; logic ordy, iv;
    logic m; logic [W-1:0] av, apv, omv, s, d; logic [TAG_W-1:0] tg;
    m = 1'($urandom_range(0, 1)); av = rnd_op(); apv = rnd_op(); omv = rnd_op(); tg = TAG_W'($urandom);
    for (int k = 0; k < 400; k++) begin
      model(m, av, apv, omv, s, d);
      ordy = ($urandom_range(0, 3) != 0);
      iv = (sent < 40) && ($urandom_range(0, 3) != 0);
      step(iv, m, av, apv, omv, tg, ordy, acc);
      tests++; if (in_ready !== !(out_valid && !out_ready)) begin fails++; $display("FAIL flow_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready)); end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL flow_spurious: out_valid=1 want no output"); end
        else begin
          e = exp_q.pop_front();
          if (b_sum !== e.s || b_diff !== e.d || tag_out !== e.tag) begin
            fails++; $display("FAIL flow_data: got %0d/%0d tag %0d want %0d/%0d tag %0d", b_sum, b_diff, tag_out, e.s, e.d, e.tag);
          end
        end
      end
      if (acc) begin
        exp_q.push_back('{s, d, tg, cyc}); sent++;
        m = 1'($urandom_range(0, 1)); av = rnd_op(); apv = rnd_op(); omv = rnd_op(); tg = TAG_W'($urandom);
      end
      if (sent == 40 && exp_q.size() == 0) break;
    end
    tests++; if (exp_q.size() != 0 || sent != 40) begin fails++; $display("FAIL flow_drain: left %0d sent %0d want 0/40", exp_q.size(), sent); end
  endtask

  task automatic test_async_reset();
    exp_t e; logic acc; logic [W-1:0] s, d;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'(k % 2), rnd_op(), rnd_op(), rnd_op(), TAG_W'(k), 1'b1, acc);
    end
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, acc);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL arst_pre_valid: got %b want 1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    tests++; if (b_sum !== '0 || b_diff !== '0 || tag_out !== '0) begin
      fails++; $display("FAIL arst_outputs: got %0d/%0d tag %0d want 0/0 tag 0", b_sum, b_diff, tag_out);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    model(1'b0, 16'd0, 16'd1, W'(MONT_ONE), s, d);
    for (int k = 0; k < 20; k++) begin
      step(k == 0, 1'b0, 16'd0, 16'd1, W'(MONT_ONE), TAG_W'(77), 1'b1, acc);
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL arst_stale: out_valid=1 tag %0d want no output", tag_out); end
        else begin
          e = exp_q.pop_front();
          if (b_sum !== e.s || b_diff !== e.d || tag_out !== e.tag) begin
            fails++; $display("FAIL arst_data: got %0d/%0d tag %0d want %0d/%0d tag %0d", b_sum, b_diff, tag_out, e.s, e.d, e.tag);
          end
          tests++; if (cyc - e.cyc != 5) begin fails++; $display("FAIL arst_latency: got %0d want 5", cyc - e.cyc); end
        end
      end
      if (acc) exp_q.push_back('{s, d, TAG_W'(77), cyc});
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL arst_drain: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    rinv = modpow(RL % QL, QL - 2, QL);
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random_flow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
